// File: rtl/audio_sample_fifo.sv
// Stereo sample FIFO feeding a DAC serializer.
//
// Producer writes {left,right} pairs on in_valid && in_ready. Each rising edge of
// lrck (sampled on clk) pops one pair. The popped pair appears on out_left and
// out_right exactly two clk edges after the edge that first samples lrck high.
// Attenuation (arithmetic right shift) and mute are applied in the final stage.
// Popping an empty FIFO holds the outputs, pulses underflow and bumps a saturating
// underrun counter.
//
// Ports:
//   clk, reset          system clock, synchronous active-high reset
//   in_valid/in_ready   write handshake; in_left/in_right signed samples
//   lrck                DAC frame clock (clk domain); rising edge requests a pop
//   atten, mute         output processing controls, sampled in the output stage
//   out_left/out_right  processed samples (two's complement or offset-binary)
//   level               FIFO occupancy 0..2^DEPTH_BITS
//   underflow           one-cycle pulse after a pop found the FIFO empty
//   underrun_cnt        saturating count of underflows
module audio_sample_fifo #(
  parameter int unsigned DEPTH_BITS   = 4,
  parameter bit          UNSIGNED_OUT = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [15:0]           in_left,
  input  logic [15:0]           in_right,
  input  logic                  lrck,
  input  logic [3:0]            atten,
  input  logic                  mute,
  output logic [15:0]           out_left,
  output logic [15:0]           out_right,
  output logic [DEPTH_BITS:0]   level,
  output logic                  underflow,
  output logic [7:0]            underrun_cnt
);

  localparam int unsigned        Depth     = 1 << DEPTH_BITS;
  localparam logic [DEPTH_BITS:0] LevelFull = (DEPTH_BITS + 1)'(Depth);
  localparam logic [15:0]        Midscale  = UNSIGNED_OUT ? 16'h8000 : 16'h0000;

  logic [31:0]           mem [Depth];
  logic [DEPTH_BITS-1:0] wptr_q, rptr_q;
  logic [DEPTH_BITS:0]   level_q, level_d;
  logic                  lrck_q;
  logic                  underflow_q;
  logic [7:0]            underrun_cnt_q;

  // Pipeline: rd_q holds the RAM read at the pop edge, s1_q the raw pair one
  // cycle later, then the processed result lands in the output registers.
  logic [31:0]           rd_q, s1_q;
  logic                  rd_vld_q, s1_vld_q;
  logic [15:0]           out_left_q, out_right_q;

  logic                  empty, wr_en, pop_req, pop_ok, pop_empty;
  logic signed [15:0]    sh_left, sh_right;
  logic [15:0]           proc_left, proc_right;

  assign empty     = (level_q == '0);
  assign in_ready  = (level_q != LevelFull);
  assign wr_en     = in_valid && in_ready;
  assign pop_req   = lrck && !lrck_q;
  // No bypass: a write in the same cycle does not rescue a pop on an empty FIFO.
  assign pop_ok    = pop_req && !empty;
  assign pop_empty = pop_req && empty;

  always_comb begin
    level_d = level_q;
    unique case ({wr_en, pop_ok})
      2'b10:   level_d = level_q + (DEPTH_BITS + 1)'(1);
      2'b01:   level_d = level_q - (DEPTH_BITS + 1)'(1);
      default: level_d = level_q;
    endcase
  end

  always_comb begin
    sh_left  = $signed(s1_q[31:16]) >>> atten;
    sh_right = $signed(s1_q[15:0]) >>> atten;
    if (mute) begin
      sh_left  = '0;
      sh_right = '0;
    end
    if (UNSIGNED_OUT) begin
      proc_left  = {~sh_left[15], sh_left[14:0]};
      proc_right = {~sh_right[15], sh_right[14:0]};
    end else begin
      proc_left  = sh_left;
      proc_right = sh_right;
    end
  end

  // Storage and data path registers carry no reset; validity is tracked separately.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wptr_q] <= {in_left, in_right};
    if (pop_ok) rd_q <= mem[rptr_q];
    if (rd_vld_q) s1_q <= rd_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q         <= '0;
      rptr_q         <= '0;
      level_q        <= '0;
      lrck_q         <= 1'b1;  // lrck high at release must not look like an edge
      underflow_q    <= 1'b0;
      underrun_cnt_q <= '0;
      rd_vld_q       <= 1'b0;
      s1_vld_q       <= 1'b0;
      out_left_q     <= Midscale;
      out_right_q    <= Midscale;
    end else begin
      lrck_q      <= lrck;
      level_q     <= level_d;
      underflow_q <= pop_empty;
      rd_vld_q    <= pop_ok;
      s1_vld_q    <= rd_vld_q;
      if (wr_en)  wptr_q <= wptr_q + DEPTH_BITS'(1);
      if (pop_ok) rptr_q <= rptr_q + DEPTH_BITS'(1);
      if (pop_empty && underrun_cnt_q != 8'hFF) underrun_cnt_q <= underrun_cnt_q + 8'd1;
      if (s1_vld_q) begin
        out_left_q  <= proc_left;
        out_right_q <= proc_right;
      end
    end
  end

  assign out_left     = out_left_q;
  assign out_right    = out_right_q;
  assign level        = level_q;
  assign underflow    = underflow_q;
  assign underrun_cnt = underrun_cnt_q;

endmodule

// File: tb/tb_audio_sample_fifo.sv
// Randomized bench for audio_sample_fifo against a queue-based reference model.
// Two instances share stimulus: two's-complement output and offset-binary output.
module tb_audio_sample_fifo;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset, in_valid, lrck, mute;
  logic [3:0]  atten;
  logic [15:0] in_left, in_right;

  logic        in_ready, underflow, u_in_ready, u_underflow;
  logic [15:0] out_left, out_right, u_out_left, u_out_right;
  logic [4:0]  level, u_level;
  logic [7:0]  underrun_cnt, u_underrun_cnt;

  always #5 clk = ~clk;

  audio_sample_fifo #(.DEPTH_BITS(4), .UNSIGNED_OUT(1'b0)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_left(in_left), .in_right(in_right), .lrck(lrck), .atten(atten), .mute(mute),
    .out_left(out_left), .out_right(out_right), .level(level), .underflow(underflow),
    .underrun_cnt(underrun_cnt)
  );

  audio_sample_fifo #(.DEPTH_BITS(4), .UNSIGNED_OUT(1'b1)) dut_u (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(u_in_ready),
    .in_left(in_left), .in_right(in_right), .lrck(lrck), .atten(atten), .mute(mute),
    .out_left(u_out_left), .out_right(u_out_right), .level(u_level),
    .underflow(u_underflow), .underrun_cnt(u_underrun_cnt)
  );

  // Reference model state
  typedef struct {
    int          due;
    logic [31:0] raw;
  } pend_t;

  logic [31:0] mq[$];
  pend_t       pend[$];
  bit          m_prev;
  int          m_cnt;
  bit          m_uf;
  logic [15:0] m_l, m_r;  // two's-complement result; offset-binary adds 0x8000
  int          cyc;
  int          n_checks, n_errors;

  task automatic check_eq(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Attenuation as floor division by 2^a; mute yields zero.
  function automatic logic [15:0] model_s(logic [15:0] raw, int a, bit m);
    int v, d, q;
    if (m) return 16'h0000;
    v = int'($signed(raw));
    d = 1 << a;
    if (v >= 0) q = v / d;
    else q = -((-v + d - 1) / d);
    return 16'(q);
  endfunction

  task automatic tick();
    bit    pop, full;
    pend_t p;
    cyc++;
    if (reset) begin
      mq.delete();
      pend.delete();
      m_prev = 1'b1;
      m_cnt  = 0;
      m_uf   = 1'b0;
      m_l    = 16'h0000;
      m_r    = 16'h0000;
    end else begin
      m_uf = 1'b0;
      if (pend.size() > 0 && pend[0].due == cyc) begin
        p   = pend.pop_front();
        m_l = model_s(p.raw[31:16], int'(atten), mute);
        m_r = model_s(p.raw[15:0], int'(atten), mute);
      end
      full = (mq.size() == DEPTH);
      pop  = !m_prev && lrck;
      if (pop) begin
        if (mq.size() > 0) pend.push_back('{due: cyc + 2, raw: mq.pop_front()});
        else begin
          m_uf = 1'b1;
          if (m_cnt < 255) m_cnt++;
        end
      end
      if (in_valid && !full) mq.push_back({in_left, in_right});
      m_prev = lrck;
    end
    @(posedge clk);
    #2;
    check_eq("level", 32'(level), 32'(mq.size()));
    check_eq("in_ready", 32'(in_ready), 32'(mq.size() != DEPTH));
    check_eq("underflow", 32'(underflow), 32'(m_uf));
    check_eq("underrun_cnt", 32'(underrun_cnt), 32'(m_cnt));
    check_eq("out_left", 32'(out_left), 32'(m_l));
    check_eq("out_right", 32'(out_right), 32'(m_r));
    check_eq("u_out_left", 32'(u_out_left), 32'(16'(m_l + 16'h8000)));
    check_eq("u_out_right", 32'(u_out_right), 32'(16'(m_r + 16'h8000)));
    check_eq("u_level", 32'(u_level), 32'(mq.size()));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic write_pair(logic [15:0] l, logic [15:0] r);
    in_valid = 1'b1;
    in_left  = l;
    in_right = r;
    tick();
    in_valid = 1'b0;
  endtask

  // One lrck rising edge, then enough cycles for the pair to reach the outputs.
  task automatic pop_and_wait();
    lrck = 1'b0;
    tick();
    lrck = 1'b1;
    tick();
    tick();
    tick();
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    cyc      = 0;
    in_valid = 1'b0;
    lrck     = 1'b0;
    mute     = 1'b0;
    atten    = 4'd0;
    in_left  = '0;
    in_right = '0;

    // Basic write then pop.
    do_reset();
    check_eq("rst_out_left", 32'(out_left), 32'h0000);
    check_eq("rst_u_out_left", 32'(u_out_left), 32'h8000);
    write_pair(16'h1234, 16'hFEDC);
    lrck = 1'b0;
    tick();
    lrck = 1'b1;
    tick();
    check_eq("pop_level0", 32'(level), 32'd0);
    check_eq("pop_not_yet", 32'(out_left), 32'h0000);
    tick();
    check_eq("pop_still_not", 32'(out_left), 32'h0000);
    tick();
    check_eq("s034_left", 32'(out_left), 32'h1234);
    check_eq("s034_right", 32'(out_right), 32'hFEDC);

    // Fill to full, 17th pair rejected, one pop frees a slot.
    in_valid = 1'b1;
    for (int i = 0; i < 17; i++) begin
      in_left  = 16'(i * 3 + 1);
      in_right = 16'(i * 5 + 2);
      tick();
    end
    check_eq("full_level", 32'(level), 32'd16);
    check_eq("full_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    lrck     = 1'b0;
    tick();
    lrck = 1'b1;
    tick();
    check_eq("after_pop_level", 32'(level), 32'd15);
    check_eq("after_pop_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 15; i++) pop_and_wait();

    // Underflow: three edges, then saturation.
    check_eq("drained", 32'(level), 32'd0);
    for (int i = 0; i < 3; i++) pop_and_wait();
    check_eq("uf3_cnt", 32'(underrun_cnt), 32'd3);
    for (int i = 0; i < 300; i++) begin
      lrck = 1'b0;
      tick();
      lrck = 1'b1;
      tick();
    end
    check_eq("uf_sat", 32'(underrun_cnt), 32'd255);

    // Processing corners.
    do_reset();
    atten = 4'd4;
    write_pair(16'h8000, 16'h7FFF);
    pop_and_wait();
    check_eq("atten4_left", 32'(out_left), 32'hF800);
    atten = 4'd0;
    write_pair(16'h7FFF, 16'h8000);
    pop_and_wait();
    check_eq("unsigned_7fff", 32'(u_out_left), 32'hFFFF);
    check_eq("unsigned_8000", 32'(u_out_right), 32'h0000);
    mute = 1'b1;
    write_pair(16'h4321, 16'hABCD);
    pop_and_wait();
    check_eq("mute_left", 32'(out_left), 32'h0000);
    check_eq("mute_u_left", 32'(u_out_left), 32'h8000);
    mute = 1'b0;

    // Simultaneous write and pop at level 5, then order over 20 pops.
    for (int i = 0; i < 5; i++) write_pair(16'(16'h100 + i), 16'(16'h200 + i));
    lrck = 1'b0;
    tick();
    in_valid = 1'b1;
    in_left  = 16'h0AAA;
    in_right = 16'h0BBB;
    lrck     = 1'b1;
    tick();
    in_valid = 1'b0;
    check_eq("wr_pop_level5", 32'(level), 32'd5);
    for (int i = 0; i < 20; i++) begin
      in_valid = ($urandom_range(0, 1) == 1);
      in_left  = 16'($urandom);
      in_right = 16'($urandom);
      lrck     = 1'b0;
      tick();
      in_valid = 1'b0;
      lrck     = 1'b1;
      tick();
    end

    // Reset one cycle after a pop, lrck held high through release.
    do_reset();
    write_pair(16'h5555, 16'h6666);
    lrck = 1'b0;
    tick();
    lrck = 1'b1;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check_eq("rst_pop_left", 32'(out_left), 32'h0000);
    check_eq("rst_pop_cnt", 32'(underrun_cnt), 32'd0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      reset    = ($urandom_range(0, 299) == 0);
      in_valid = ($urandom_range(0, 2) != 0);
      in_left  = 16'($urandom);
      in_right = 16'($urandom);
      if ($urandom_range(0, 2) == 0) lrck = ~lrck;
      atten = 4'($urandom);
      mute  = ($urandom_range(0, 7) == 0);
      tick();
    end
    reset = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/audio_sample_fifo.md
AUDIO_SAMPLE_FIFO -- requirements
Module: audio_sample_fifo

Interface
REQ-001 The block SHALL have parameter DEPTH_BITS, default 4, meaning log2 of FIFO depth in stereo pairs (16 entries).
REQ-002 The block SHALL have parameter UNSIGNED_OUT, default 0, meaning that 1 inverts the MSB of both outputs (offset-binary) and 0 keeps two's complement.
REQ-003 The block SHALL have port clk, input, 1, system clock 28 MHz.
REQ-004 The block SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 The block SHALL have port in_valid, input, 1, producer offers a stereo pair.
REQ-006 The block SHALL have port in_ready, output, 1, FIFO accepts a pair this cycle.
REQ-007 The block SHALL have ports in_left and in_right, input, 16 each, signed two's-complement samples.
REQ-008 The block SHALL have port lrck, input, 1, DAC frame clock from the serializer, in the clk domain.
REQ-009 The block SHALL have port atten, input, 4, arithmetic right-shift amount 0..15.
REQ-010 The block SHALL have port mute, input, 1, which forces midscale output.
REQ-011 The block SHALL have ports out_left and out_right, output, 16 each, samples to the DAC serializer.
REQ-012 The block SHALL have port level, output, DEPTH_BITS+1, current FIFO occupancy.
REQ-013 The block SHALL have port underflow, output, 1, one-cycle pulse when a pop finds the FIFO empty.
REQ-014 The block SHALL have port underrun_cnt, output, 8, saturating count of underflows.

Function
REQ-015 Storage SHALL be 2^DEPTH_BITS entries of 32 bits ({left,right}), with read/write pointers of DEPTH_BITS bits that wrap modulo depth.
REQ-016 in_ready SHALL equal (level != 2^DEPTH_BITS), derived from registered state only; a write occurs when in_valid && in_ready.
REQ-017 A write SHALL store the pair at wptr, increment wptr, and take effect at the next clk edge.
REQ-018 A pop request SHALL be the lrck rising edge: lrck_q==0 && lrck==1, where lrck_q is lrck registered on clk.
REQ-019 On a pop request with level>0, the entry at rptr SHALL be read and rptr incremented.
REQ-020 On a pop request with level==0, the pointers SHALL be unchanged, the outputs SHALL hold their previous values, underflow SHALL pulse for 1 cycle in the following cycle, and underrun_cnt SHALL increment, saturating at 255.
REQ-021 A simultaneous write and pop SHALL both proceed and leave level unchanged.
REQ-022 A write into an empty FIFO SHALL NOT satisfy a pop in the same cycle: that pop is an underflow, with no bypass path.
REQ-023 The write is qualified by in_ready, so a write while full SHALL NOT occur even when a pop happens in the same cycle.
REQ-024 Pipeline stage 1 (cycle after pop) SHALL register the raw pair; stage 2 SHALL register the processed outputs.
REQ-025 out_left and out_right SHALL change exactly 2 clk after the clk edge at which lrck is first sampled high, and at no other time.
REQ-026 Processing SHALL be per channel: s = raw >>> atten (sign-extending); if mute, s = 0; if UNSIGNED_OUT, out = {~s[15], s[14:0]}, else out = s.
REQ-027 atten and mute SHALL be sampled at stage 2 only, with no output change between pops.
REQ-028 level SHALL range 0..2^DEPTH_BITS and update in the same cycle as the pointers.

Reset
REQ-029 On reset, the pointers, level and underrun_cnt SHALL be 0, underflow 0, and the pipeline valid bits cleared.
REQ-030 On reset, out_left and out_right SHALL be midscale: 16'h0000, or 16'h8000 when UNSIGNED_OUT=1.
REQ-031 On reset, lrck_q SHALL be 1, so that lrck high at reset release does not create a pop.
REQ-032 Reset asserted mid-operation SHALL discard FIFO contents and any in-flight pipeline data, with no output update from a pop issued in the cycle reset is asserted.
REQ-033 The stored RAM contents need not be reset.

Verification
REQ-034 Scenario: reset, write pair (0x1234, 0xFEDC), then lrck 0->1 -> at +2 clk out_left=0x1234, out_right=0xFEDC, level back to 0.
REQ-035 Scenario: fill 16 pairs with in_valid held -> in_ready=0 at level 16 and the 17th pair is not accepted; one pop -> in_ready=1 the next cycle, level=15.
REQ-036 Scenario: empty FIFO, 3 lrck rising edges -> 3 underflow pulses, underrun_cnt=3, outputs held at the last value; 300 edges -> underrun_cnt=255.
REQ-037 Scenario: sample 0x8000 with atten=4 -> out=0xF800; mute=1 -> out=0x0000; UNSIGNED_OUT=1 with 0x7FFF -> out=0xFFFF.
REQ-038 Scenario: a write and a pop in the same cycle at level 5 -> level stays 5 and FIFO order is preserved over 20 subsequent pops.
REQ-039 Scenario: reset asserted 1 cycle after a pop with lrck held high through release -> outputs midscale, no pop until the next lrck rising edge.
